fu_result_collector: RTL
========================

# fu_result_collector

Gathers results from the seven functional units (add, sub, mul, div, and, or, xor) and returns them to the register-file writeback port as one registered stream. It is the return path of the operand demux: the demux fans rs1 out to the units by opcode, and this block fans their results back in. Each unit has a valid/ready handshake, and the writeback side has its own. When several units complete together, the block arbitrates between them.

## Interface
Parameters:
- N, 16, data width of a result
- SEL_LINE, 4, opcode width
- RD_W, 4, destination register index width
- NUM_FU, 7, number of functional units (fixed at 7; unit index i occupies bits [i*N +: N] and [i*RD_W +: RD_W])

Ports (unit index: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor):
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- fu_valid  input  NUM_FU  unit i has a result pending
- fu_result  input  NUM_FU*N  packed unit results
- fu_rd  input  NUM_FU*RD_W  packed destination register indices
- fu_ready  output  NUM_FU  one-hot or zero; unit i's result is taken this cycle
- wb_valid  output  1  writeback entry present
- wb_ready  input  1  register file accepts the entry
- wb_data  output  N  result value
- wb_rd  output  RD_W  destination register
- wb_opcode  output  SEL_LINE  originating opcode: add 0000, sub 0001, mul 0010, div 0011, and 0100, or 0101, xor 0110
- stall_cnt  output  16  saturating count of cycles in which at least one valid unit was not granted

## Operation
- The output stage is a single register slot (wb_valid, wb_data, wb_rd, wb_opcode).
- load_ok = !wb_valid | wb_ready.
- The grant goes to one unit with fu_valid=1, chosen by the arbiter (see Configuration).
- fu_ready[g] = load_ok & fu_valid[g]; all other fu_ready bits are 0.
  - fu_ready depends combinationally on fu_valid, wb_valid and wb_ready.
  - A unit must not make fu_valid depend on fu_ready.
- A transfer is fu_valid[g] & fu_ready[g]. On a transfer:
  - If rd != 0: the slot loads result, rd and the opcode code of g; wb_valid becomes 1.
  - If rd == 0: the result is consumed and dropped (r0 is hardwired zero). The slot behaves as if no load occurred, so wb_valid becomes 0 when it is drained the same cycle.
- With no transfer, wb_valid & wb_ready clears wb_valid.
- While wb_valid=1 and wb_ready=0, wb_data, wb_rd and wb_opcode hold stable.
- stall_cnt increments when the count of valid units exceeds the count of transfers that cycle. It saturates at 16'hFFFF.
- A fu_valid bit for an index >= NUM_FU does not exist. Opcodes 0111–1111 are never produced.

## Timing
- Reset values: wb_valid 0, wb_data 0, wb_rd 0, wb_opcode 0, stall_cnt 0, arbiter pointer 6.
  - fu_ready is 0 while rst_n=0.
- Reset asserted mid-transfer discards the slot contents and any pending grant immediately. Units must re-present their results after reset.
- Latency is one cycle from a transfer edge to wb_valid=1.
- Throughput is one result per cycle when wb_ready stays 1.
- Simultaneous drain and load in the same cycle is supported; wb_valid stays 1 with the new entry.
- The wb_valid/wb_ready handshake follows standard rules: wb_valid never drops without acceptance, except on reset.

## Configuration
- RESULT_COLLECTOR_RR_EN defined: round-robin arbitration.
  - The search starts at pointer+1 mod 7 and wraps 6→0.
  - The pointer updates to g only on a transfer, including rd==0 drops.
  - No unit waits more than 6 transfers.
- Not defined: fixed priority, where the lowest valid index wins. The pointer is not implemented.
- stall_cnt behaviour is identical in both builds.

## Test plan
- Single add result:
  - Stimulus: fu_valid=0000001, result 16'h1234, rd 3, wb_ready=1.
  - Required: fu_ready[0]=1 that cycle; next cycle wb_valid=1, wb_data=16'h1234, wb_rd=3, wb_opcode=0000.
- Backpressure:
  - Stimulus: a mul result (16'h00FF, rd 5) loaded while wb_ready=0 for 4 cycles and the div unit is valid.
  - Required: wb_* stays 16'h00FF/5/0010, fu_ready=0, and stall_cnt rises by 4.
- rd==0 drop:
  - Stimulus: xor valid with rd 0.
  - Required: fu_ready[6]=1 and wb_valid remains 0.
- Arbitration, all 7 units valid continuously with wb_ready=1:
  - With RR_EN: grants go 0,1,2,3,4,5,6,0 on consecutive cycles.
  - Without RR_EN: the grant is 0 until unit 0 drops fu_valid.
- Async reset mid-stream:
  - Stimulus: pull rst_n low between clock edges while wb_valid=1.
  - Required: wb_valid=0 and stall_cnt=0 immediately, without waiting for a clock edge.
- Saturation:
  - Stimulus: hold two units valid with wb_ready=0 for more than 65535 cycles.
  - Required: stall_cnt stops at 16'hFFFF.

Source files
------------

// File: rtl/fu_result_collector.sv
// fu_result_collector: fans the seven functional-unit results back into one registered writeback slot.
// Define RESULT_COLLECTOR_RR_EN for round-robin arbitration; otherwise the lowest valid unit index wins.
module fu_result_collector #(
  parameter int N        = 16,
  parameter int SEL_LINE = 4,
  parameter int RD_W     = 4,
  parameter int NUM_FU   = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_FU-1:0]        fu_valid,
  input  logic [NUM_FU*N-1:0]      fu_result,
  input  logic [NUM_FU*RD_W-1:0]   fu_rd,
  output logic [NUM_FU-1:0]        fu_ready,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [N-1:0]             wb_data,
  output logic [RD_W-1:0]          wb_rd,
  output logic [SEL_LINE-1:0]      wb_opcode,
  output logic [15:0]              stall_cnt
);

  logic                wbValid_q, wbValid_d;
  logic [N-1:0]        wbData_q, wbData_d;
  logic [RD_W-1:0]     wbRd_q, wbRd_d;
  logic [SEL_LINE-1:0] wbOpcode_q, wbOpcode_d;
  logic [15:0]         stallCnt_q, stallCnt_d;

  logic                loadOk;
  logic                anyValid;
  logic                transfer;
  logic [2:0]          grant;
  logic [N-1:0]        selData;
  logic [RD_W-1:0]     selRd;
  logic [2:0]          validCnt;

`ifdef RESULT_COLLECTOR_RR_EN
  logic [2:0]          ptr_q, ptr_d;
  logic [3:0]          idx;
`endif

  assign loadOk   = !wbValid_q || wb_ready;
  assign transfer = rst_n && loadOk && anyValid;

  always_comb begin
    grant    = 3'd0;
    anyValid = 1'b0;
`ifdef RESULT_COLLECTOR_RR_EN
    idx = 4'd0;
    // Search starts one past the last granted unit and wraps 6 -> 0.
    for (int k = 0; k < NUM_FU; k++) begin
      idx = {1'b0, ptr_q} + 4'd1 + 4'(k);
      if (idx >= 4'(NUM_FU)) idx = idx - 4'(NUM_FU);
      if (!anyValid && fu_valid[idx[2:0]]) begin
        grant    = idx[2:0];
        anyValid = 1'b1;
      end
    end
`else
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      if (fu_valid[k]) begin
        grant    = 3'(k);
        anyValid = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    selData  = '0;
    selRd    = '0;
    validCnt = 3'd0;
    fu_ready = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      validCnt = validCnt + 3'(fu_valid[i]);
      if (grant == 3'(i)) begin
        selData = fu_result[i*N +: N];
        selRd   = fu_rd[i*RD_W +: RD_W];
      end
    end
    if (transfer) fu_ready[grant] = 1'b1;
  end

  always_comb begin
    wbValid_d  = wbValid_q;
    wbData_d   = wbData_q;
    wbRd_d     = wbRd_q;
    wbOpcode_d = wbOpcode_q;
    stallCnt_d = stallCnt_q;
    // Results aimed at r0 are accepted from the unit but never reach the slot.
    if (transfer && selRd != '0) begin
      wbValid_d  = 1'b1;
      wbData_d   = selData;
      wbRd_d     = selRd;
      wbOpcode_d = SEL_LINE'(grant);
    end else if (wbValid_q && wb_ready) begin
      wbValid_d = 1'b0;
    end
    if (validCnt > {2'b00, transfer} && stallCnt_q != 16'hFFFF)
      stallCnt_d = stallCnt_q + 16'd1;
  end

`ifdef RESULT_COLLECTOR_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (transfer) ptr_d = grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 3'd6;
    else        ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbValid_q  <= 1'b0;
      wbData_q   <= '0;
      wbRd_q     <= '0;
      wbOpcode_q <= '0;
      stallCnt_q <= 16'd0;
    end else begin
      wbValid_q  <= wbValid_d;
      wbData_q   <= wbData_d;
      wbRd_q     <= wbRd_d;
      wbOpcode_q <= wbOpcode_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign wb_valid  = wbValid_q;
  assign wb_data   = wbData_q;
  assign wb_rd     = wbRd_q;
  assign wb_opcode = wbOpcode_q;
  assign stall_cnt = stallCnt_q;

endmodule
